// File: rtl/fpm_pkg.sv
//------------------------------------------------------------------------------
// Module      : fpm_pkg
// Description : Shared types and constants for the FP multiplier result packer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fpm_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frc;
    } fp32_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam int          FP_EXP_MAX = 255;
    localparam int          FP_BIAS    = 127;

    // Bit positions inside the {NV,OF,UF,NX} flag nibble
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic fp32_t fp_pack(input logic s, input logic [7:0] e, input logic [22:0] f);
        fp32_t r;
        r.sign = s;
        r.exp  = e;
        r.frc  = f;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpm_round.sv
//------------------------------------------------------------------------------
// Module      : fpm_round
// Description : Combinational normalise + round-to-nearest-even of a 48-bit
//               significand product into a 23-bit fraction and adjusted exponent.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fpm_round #(
    parameter int EXP_W = 10
) (
    input  logic [47:0]    i_mant,
    input  logic [EXP_W-1:0] i_exp,
    output logic [EXP_W:0] o_exp,
    output logic [22:0]    o_frc,
    output logic           o_nx
);

    logic [46:0]    w_m;
    logic [EXP_W:0] w_exp_n;
    logic           w_g;
    logic           w_s;
    logic           w_inc;
    logic [24:0]    w_sum;
    logic           w_unused_hidden;

    always_comb begin
        w_exp_n = {i_exp[EXP_W-1], i_exp} + {{EXP_W{1'b0}}, i_mant[47]};
        w_m     = i_mant[47] ? i_mant[47:1] : i_mant[46:0];
        w_g     = w_m[22];
        w_s     = |w_m[21:0];
        w_inc   = w_g & (w_s | w_m[23]);
        w_sum   = {1'b0, w_m[46:23]} + {24'b0, w_inc};
        o_nx    = w_g | w_s;
        // A carry out of the hidden bit means the significand became 10.0...0
        if (w_sum[24]) begin
            o_frc = 23'b0;
            o_exp = w_exp_n + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            o_frc = w_sum[22:0];
            o_exp = w_exp_n;
        end
    end

    assign w_unused_hidden = w_sum[23];

endmodule

`default_nettype wire

// File: rtl/fpm_pack.sv
//------------------------------------------------------------------------------
// Module      : fpm_pack
// Description : 2-stage FP multiplier result encoder (normalise, RNE, special
//               case select, IEEE-754 single pack). Optional sticky status
//               register enabled by the FPM_STATUS_EN macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fpm_pack
    import fpm_pkg::*;
#(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = FP_QNAN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             in_zer,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [3:0]       out_flags,
    input  logic             stat_clr,
    output logic [3:0]       stat_flags
);

    localparam logic [EXP_W:0] c_EXP_OVF = (EXP_W+1)'(FP_EXP_MAX);

    logic           r_s1_v;
    logic           r_s1_sign;
    logic [EXP_W:0] r_s1_exp;
    logic [22:0]    r_s1_frc;
    logic           r_s1_nx;
    logic           r_s1_nan;
    logic           r_s1_inf;
    logic           r_s1_zer;

    logic           r_s2_v;
    logic [31:0]    r_word;
    logic [3:0]     r_flags;

    logic           w_s1_adv;
    logic [EXP_W:0] w_rnd_exp;
    logic [22:0]    w_rnd_frc;
    logic           w_rnd_nx;
    fp32_t          w_word;
    logic [3:0]     w_flags;

    assign w_s1_adv = ~r_s2_v | out_ready;
    assign in_ready = ~r_s1_v | w_s1_adv;

    fpm_round #(
        .EXP_W (EXP_W)
    ) u_round (
        .i_mant (in_mant),
        .i_exp  (in_exp),
        .o_exp  (w_rnd_exp),
        .o_frc  (w_rnd_frc),
        .o_nx   (w_rnd_nx)
    );

    // Stage 1: valid bit resets, payload is don't-care until valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            r_s1_sign <= in_sign;
            r_s1_exp  <= w_rnd_exp;
            r_s1_frc  <= w_rnd_frc;
            r_s1_nx   <= w_rnd_nx;
            r_s1_nan  <= in_nan;
            r_s1_inf  <= in_inf;
            r_s1_zer  <= in_zer;
        end
    end

    always_comb begin
        w_word  = fp_pack(r_s1_sign, r_s1_exp[7:0], r_s1_frc);
        w_flags = 4'b0;
        if (r_s1_nan) begin
            w_word           = QNAN;
            w_flags[FLAG_NV] = 1'b1;
        end else if (r_s1_inf) begin
            w_word = fp_pack(r_s1_sign, 8'hFF, 23'b0);
        end else if (r_s1_zer) begin
            w_word = fp_pack(r_s1_sign, 8'h00, 23'b0);
        end else if ($signed(r_s1_exp) >= $signed(c_EXP_OVF)) begin
            w_word           = fp_pack(r_s1_sign, 8'hFF, 23'b0);
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else if ($signed(r_s1_exp) <= $signed({(EXP_W+1){1'b0}})) begin
            w_word           = fp_pack(r_s1_sign, 8'h00, 23'b0);
            w_flags[FLAG_UF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else begin
            w_flags[FLAG_NX] = r_s1_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v  <= 1'b0;
            r_word  <= 32'b0;
            r_flags <= 4'b0;
        end else if (w_s1_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_word  <= w_word;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_word  = r_word;
    assign out_flags = r_flags;

`ifdef FPM_STATUS_EN
    logic [3:0] r_stat;

    // Clear applies to the old value only, so bits set this cycle survive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= 4'b0;
        end else begin
            r_stat <= (stat_clr ? 4'b0 : r_stat) | ((r_s2_v & out_ready) ? r_flags : 4'b0);
        end
    end

    assign stat_flags = r_stat;
`else
    logic w_unused_stat;

    assign w_unused_stat = stat_clr;
    assign stat_flags    = 4'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpm_pack.sv
//------------------------------------------------------------------------------
// Module      : tb_fpm_pack
// Description : Self-checking bench for fpm_pack against an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fpm_pack;

    localparam int EXP_W = 10;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan;
        logic        inf;
        logic        zer;
    } beat_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  flags;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_zer = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [3:0]  out_flags;
    logic        stat_clr = 1'b0;
    logic [3:0]  stat_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpm_pack #(
        .EXP_W (EXP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_nan     (in_nan),
        .in_inf     (in_inf),
        .in_zer     (in_zer),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_flags  (out_flags),
        .stat_clr   (stat_clr),
        .stat_flags (stat_flags)
    );

    // Reference: real-valued significand m/2^46 scaled to [1,2), rounded to 23 fraction bits
    function automatic res_t model(input beat_t b);
        res_t   r;
        longint m;
        longint sig;
        longint rem;
        longint half;
        int     e;
        bit     nx;
        m    = longint'(b.mant);
        e    = int'($signed(b.exp));
        half = 64'sd1 << 22;
        if (m >= (64'sd1 << 47)) begin
            m = m >> 1;
            e = e + 1;
        end
        sig = m >> 23;
        rem = m % (64'sd1 << 23);
        nx  = (rem != 0);
        if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
        if (sig == (64'sd1 << 24)) begin
            sig = 64'sd1 << 23;
            e   = e + 1;
        end
        r.flags = 4'b0;
        if (b.nan) begin
            r.word  = 32'h7FC0_0000;
            r.flags = 4'b1000;
        end else if (b.inf) begin
            r.word = {b.sign, 8'hFF, 23'h0};
        end else if (b.zer) begin
            r.word = {b.sign, 31'h0};
        end else if (e >= 255) begin
            r.word  = {b.sign, 8'hFF, 23'h0};
            r.flags = 4'b0101;
        end else if (e <= 0) begin
            r.word  = {b.sign, 31'h0};
            r.flags = 4'b0011;
        end else begin
            r.word  = {b.sign, 8'(e), 23'(sig - (64'sd1 << 23))};
            r.flags = {3'b000, nx};
        end
        return r;
    endfunction

    function automatic beat_t mk(input logic s, input int e, input logic [47:0] m,
                                 input logic n, input logic i, input logic z);
        beat_t b;
        b.sign = s;
        b.exp  = 10'(e);
        b.mant = m;
        b.nan  = n;
        b.inf  = i;
        b.zer  = z;
        return b;
    endfunction

    task automatic rand_beat(output beat_t b);
        logic [31:0] r0;
        logic [31:0] r1;
        logic [47:0] m;
        int          e;
        r0 = $urandom;
        r1 = $urandom;
        m[47:46] = 2'($urandom_range(1, 3));
        m[45:32] = r1[13:0];
        m[31:0]  = r0;
        case ($urandom_range(0, 3))
            0:       e = $urandom_range(0, 1023);
            1:       e = 250 + $urandom_range(0, 8);
            2:       e = -3 + $urandom_range(0, 5);
            default: e = $urandom_range(1, 250);
        endcase
        case ($urandom_range(0, 3))
            1: begin
                if (m[47]) begin m[23] = 1'b1; m[22:0] = '0; end
                else       begin m[22] = 1'b1; m[21:0] = '0; end
            end
            2: begin
                if (m[47]) begin m[46:23] = '1; end
                else       begin m[46:22] = '1; end
            end
            default: ;
        endcase
        if (m[47]) m[0] = 1'b0;
        b = mk(1'($urandom), e, m, ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    endtask

    task automatic set_beat(input beat_t b);
        in_sign = b.sign;
        in_exp  = b.exp;
        in_mant = b.mant;
        in_nan  = b.nan;
        in_inf  = b.inf;
        in_zer  = b.zer;
    endtask

    // Push one beat through an empty pipeline; returns the result and cycles to out_valid
    task automatic send_one(input beat_t b, output res_t r, output int lat);
        int w;
        set_beat(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r.word  = out_word;
        r.flags = out_flags;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || out_flags !== 4'h0 || stat_flags !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b w=%h f=%h s=%h, want 0/0/0/0",
                     out_valid, out_word, out_flags, stat_flags);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        beat_t b[6];
        res_t  want[6];
        res_t  r;
        int    lat;
        b[0] = mk(0, 127, 48'h9000_0000_0000, 0, 0, 0);
        b[1] = mk(0, 127, 48'h4000_01C0_0000, 0, 0, 0);
        b[2] = mk(0, 300, 48'h4000_0000_0000, 0, 0, 0);
        b[3] = mk(1, -16, 48'h4000_0000_0000, 0, 0, 0);
        b[4] = mk(0, 127, 48'h4000_0000_0000, 1, 1, 1);
        b[5] = mk(1, 127, 48'h4000_0000_0000, 0, 1, 0);
        want[0] = '{32'h4010_0000, 4'b0000};
        want[1] = '{32'h3F80_0004, 4'b0001};
        want[2] = '{32'h7F80_0000, 4'b0101};
        want[3] = '{32'h8000_0000, 4'b0011};
        want[4] = '{32'h7FC0_0000, 4'b1000};
        want[5] = '{32'hFF80_0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            send_one(b[i], r, lat);
            n_tests++;
            if (r.word !== want[i].word || r.flags !== want[i].flags) begin
                n_fail++;
                $display("FAIL directed_%0d: got word=%h flags=%b want word=%h flags=%b",
                         i, r.word, r.flags, want[i].word, want[i].flags);
            end
            if (i == 0) begin
                n_tests++;
                if (lat != 2) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles want 2", lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t b[3];
        res_t  want[3];
        int    idx;
        int    got;
        int    cyc;
        for (int i = 0; i < 3; i++) begin
            rand_beat(b[i]);
            want[i] = model(b[i]);
        end
        idx = 0;
        got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_beat(b[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready && idx < 2) idx++;
            else if (in_ready) idx = 99;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (idx != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got accepted=%0d in_ready=%b want accepted=2 in_ready=0",
                     idx, in_ready);
        end
        if (idx > 2) idx = 2;
        out_ready = 1'b1;
        cyc = 0;
        while ((got < 3 || idx < 3) && cyc < 20) begin
            if (idx < 3) begin
                set_beat(b[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if (got >= 3) begin
                    n_fail++;
                    $display("FAIL bp_extra: got word=%h want no result", out_word);
                end else if (out_word !== want[got].word || out_flags !== want[got].flags) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: got word=%h flags=%b want word=%h flags=%b",
                             got, out_word, out_flags, want[got].word, want[got].flags);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (got != 3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results out_valid=%b want 3 results then idle",
                     got, out_valid);
        end
    endtask

    task automatic test_random();
        res_t  q[$];
        res_t  exp_r;
        beat_t cur;
        int    sent;
        int    cyc;
        sent = 0;
        cyc  = 0;
        while ((sent < 400 || q.size() > 0) && cyc < 5000) begin
            if (sent < 400 && $urandom_range(0, 3) != 0) begin
                rand_beat(cur);
                set_beat(cur);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: got word=%h want no result", out_word);
                end else begin
                    exp_r = q.pop_front();
                    if (out_word !== exp_r.word || out_flags !== exp_r.flags) begin
                        n_fail++;
                        $display("FAIL rand_result: got word=%h flags=%b want word=%h flags=%b",
                                 out_word, out_flags, exp_r.word, exp_r.flags);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cur));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (cyc >= 5000) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d sent %0d pending want all drained", sent, q.size());
        end
    endtask

`ifdef FPM_STATUS_EN
    task automatic test_status();
        res_t r;
        int   lat;
        int   w;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        send_one(mk(0, 300, 48'h4000_0000_0000, 0, 0, 0), r, lat);
        send_one(mk(0, 127, 48'h4000_0000_0000, 1, 0, 0), r, lat);
        n_tests++;
        if (stat_flags !== 4'b1101) begin
            n_fail++;
            $display("FAIL stat_accum: got %b want 1101", stat_flags);
        end
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        n_tests++;
        if (stat_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL stat_clear: got %b want 0000", stat_flags);
        end
        out_ready = 1'b0;
        set_beat(mk(0, 127, 48'h4000_01C0_0000, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        stat_clr  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        n_tests++;
        if (stat_flags !== 4'b0001) begin
            n_fail++;
            $display("FAIL stat_clr_set: got %b want 0001", stat_flags);
        end
    endtask
`else
    task automatic test_status();
        res_t r;
        int   lat;
        send_one(mk(0, 300, 48'h4000_0000_0000, 1, 0, 0), r, lat);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        n_tests++;
        if (stat_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL stat_tied: got %b want 0000", stat_flags);
        end
    endtask
`endif

    task automatic test_reset_mid();
        beat_t b;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_beat(b);
            b.nan = 1'b0;
            set_beat(b);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || out_flags !== 4'h0 ||
            stat_flags !== 4'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b w=%h f=%b s=%b rdy=%b want 0/0/0/0/1",
                     out_valid, out_word, out_flags, stat_flags, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_drop_%0d: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_status();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
